cplx_accum: RTL
===============

// Module: cplx_accum
// PURPOSE
//  Downstream stage of the pipelined complex multiplier (part1/part2).
//  Consumes its 44-bit signed re/im products and accumulates a frame of
//  LEN products, or fewer if in_last ends the frame early, into one
//  complex sum. This is a complex dot-product / correlator back end.
//  Emits one saturated result per frame on a valid/ready output.
// PARAMETERS
//  IN_W   44  width of signed in_re/in_im (multiplier product width)
//  ACC_W  48  width of signed accumulator and out_re/out_im; ACC_W >= IN_W
//  LEN    16  maximum samples per frame; >= 1
//  CNT_W  $clog2(LEN+1)  width of out_count (derived; do not override)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      in_re/in_im/in_last valid this cycle
//  in_ready   out  1      stage can accept a sample
//  in_re      in   IN_W   signed real part of product
//  in_im      in   IN_W   signed imaginary part of product
//  in_last    in   1      accepted sample closes the frame early
//  out_valid  out  1      result held on out_* ports
//  out_ready  in   1      consumer takes result
//  out_re     out  ACC_W  signed saturated real sum
//  out_im     out  ACC_W  signed saturated imaginary sum
//  out_count  out  CNT_W  samples in this frame (1..LEN)
//  out_ovf    out  1      saturation occurred in this frame (either component)
// BEHAVIOUR
//  Reset: all registers, including out_*, acc, cnt and ovf, clear to 0; state=ACC.
//    in_ready=0 while rst=1 and goes to 1 in the first cycle after.
//  States: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
//  Accept: in_valid & in_ready. in_valid while in_ready=0 is ignored, not queued.
//  ACC, on accept: acc_re/acc_im <= sat(acc + sext(in)), computed per component.
//    ovf |= saturation of either component. cnt <= cnt+1.
//  Frame end: an accept with cnt==LEN-1 or in_last=1.
//    out_re/out_im <= sat(acc + in). out_count <= cnt+1. out_ovf <= ovf | sat_now.
//    acc, cnt and ovf clear. State -> HOLD.
//    out_valid rises in the cycle after the closing accept (latency 1).
//  HOLD: out_* stable until out_valid & out_ready, then state -> ACC.
//    No sample is accepted in the cycle of the handoff. Throughput is LEN
//    samples per LEN+1 cycles when out_ready is held at 1.
//  Saturation: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] on every add.
//    A saturated partial sum is the base for the next add; no wrap-around ever.
//  Idle: in_valid gaps leave acc and cnt unchanged. There is no timeout.
//  in_last on the LEN-th sample behaves the same as without in_last.
//  Reset mid-frame or in HOLD: the partial frame or pending result is discarded.
// STRUCTURE
//  complex_pkg holds:
//    - localparams CPLX_PROD_W=44 and CPLX_ACC_W=48
//    - state encoding ST_ACC=1'b0, ST_HOLD=1'b1
//    - function sat_add(a,b) for shared clamp logic
//  Sub-module cplx_sat_add (W param) is a combinational signed adder with
//    clamp and an overflow flag. It is instantiated twice (re and im) and
//    serves both the accumulate path and the closing path.
//  Control FSM, counter and output registers live in cplx_accum.
// TESTING
//  1 LEN=4, four back-to-back (-5+10i) with out_ready=1 -> one cycle later
//    out=-20+40i, out_count=4, out_ovf=0; in_ready low exactly 1 cycle.
//  2 LEN=4, (-5+10i) then (-13+82i) with in_last=1 -> out=-18+92i,
//    out_count=2; the next frame starts at zero.
//  3 out_ready=0 for 5 cycles in HOLD while in_valid=1 with (7+7i) ->
//    out stays -20+40i and in_ready=0; after the handoff the first
//    accepted sample is the (7+7i) then presented.
//  4 ACC_W=45, LEN=4: three of (2^43-1) + 0i -> out_re=2^44-1, out_ovf=1.
//    Four of (-2^43) -> out_re=-2^44, out_ovf=1.
//  5 rst pulsed after 2 of 4 samples (1+1i) -> outputs 0. Then
//    4x(1+1i) -> out=4+4i, out_count=4 (no stale partial sum).
//  6 LEN=4, samples (1+0i),(2+0i),(3+0i),(4+0i) with 3 idle cycles
//    between each -> out=10+0i, out_count=4; no extra out_valid pulses.

Source files
------------

// File: rtl/complex_pkg.sv
// Shared types and helpers for the complex multiply/accumulate datapath.
//   CPLX_PROD_W : signed product width delivered by the complex multiplier
//   CPLX_ACC_W  : default signed accumulator width
//   state_e     : accumulator control states
//   sat_add     : signed add with clamp to a w-bit signed range
package complex_pkg;

    localparam int unsigned CPLX_PROD_W = 44;
    localparam int unsigned CPLX_ACC_W  = 48;

    // Internal working width of sat_add; callers sign-extend into it.
    localparam int unsigned SAT_W = 64;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    typedef struct packed {
        logic [SAT_W-1:0] sum;
        logic             ovf;
    } sat_res_t;

    // a + b clamped to [-2^(w-1), 2^(w-1)-1]; ovf flags that the clamp engaged.
    // Requires w <= SAT_W and a, b already inside the w-bit range.
    function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                         input logic signed [SAT_W-1:0] b,
                                         input int unsigned             w);
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sat_res_t              res;
        sum = (SAT_W+1)'(a) + (SAT_W+1)'(b);
        hi  = ((SAT_W+1)'(1) << (w - 1)) - (SAT_W+1)'(1);
        lo  = ~hi;
        if (sum > hi) begin
            res.sum = hi[SAT_W-1:0];
            res.ovf = 1'b1;
        end else if (sum < lo) begin
            res.sum = lo[SAT_W-1:0];
            res.ovf = 1'b1;
        end else begin
            res.sum = sum[SAT_W-1:0];
            res.ovf = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/cplx_sat_add.sv
// Combinational W-bit signed adder with saturation.
//   a, b  : signed operands (W bits)
//   sum_c : a + b clamped to the W-bit signed range
//   ovf_c : clamp engaged
module cplx_sat_add
    import complex_pkg::*;
#(
    parameter int unsigned W = CPLX_ACC_W
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum_c,
    output logic                ovf_c
);

    sat_res_t res;

    always_comb begin
        res   = sat_add(SAT_W'(a), SAT_W'(b), W);
        sum_c = W'(res.sum);
        ovf_c = res.ovf;
    end

    // Upper working bits are only a sign extension of sum_c.
    if (W < SAT_W) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^res.sum[SAT_W-1:W];
    end

endmodule

// File: rtl/cplx_accum.sv
// Complex accumulator: sums a frame of up to LEN signed complex products
// (or fewer, if in_last closes it early) with saturation, then holds the
// result on a valid/ready output until taken.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake
//   in_re, in_im, in_last : signed product sample and early frame end
//   out_valid/out_ready   : output handshake
//   out_re, out_im        : saturated frame sums
//   out_count             : samples in the frame (1..LEN)
//   out_ovf               : saturation happened somewhere in the frame
module cplx_accum
    import complex_pkg::*;
#(
    parameter  int unsigned IN_W  = CPLX_PROD_W,
    parameter  int unsigned ACC_W = CPLX_ACC_W,
    parameter  int unsigned LEN   = 16,
    localparam int unsigned CNT_W = $clog2(LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_re,
    input  logic signed [IN_W-1:0]  in_im,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_re,
    output logic signed [ACC_W-1:0] out_im,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_ovf
);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_re_q, acc_re_d;
    logic signed [ACC_W-1:0] acc_im_q, acc_im_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic signed [ACC_W-1:0] out_re_q, out_re_d;
    logic signed [ACC_W-1:0] out_im_q, out_im_d;
    logic [CNT_W-1:0]        out_count_q, out_count_d;
    logic                    out_ovf_q, out_ovf_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;

    logic signed [ACC_W-1:0] in_re_ext_c, in_im_ext_c;
    logic signed [ACC_W-1:0] sum_re_c, sum_im_c;
    logic                    sat_re_c, sat_im_c;
    logic                    accept_c;

    assign in_re_ext_c = ACC_W'(in_re);
    assign in_im_ext_c = ACC_W'(in_im);
    assign accept_c    = in_valid && in_ready_q;

    // One adder per component feeds both the running sum and the closing result.
    cplx_sat_add #(.W(ACC_W)) u_add_re (
        .a     (acc_re_q),
        .b     (in_re_ext_c),
        .sum_c (sum_re_c),
        .ovf_c (sat_re_c)
    );

    cplx_sat_add #(.W(ACC_W)) u_add_im (
        .a     (acc_im_q),
        .b     (in_im_ext_c),
        .sum_c (sum_im_c),
        .ovf_c (sat_im_c)
    );

    // Next-state, accumulate and result capture.
    always_comb begin
        state_d     = state_q;
        acc_re_d    = acc_re_q;
        acc_im_d    = acc_im_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            ST_ACC: begin
                if (accept_c) begin
                    if (in_last || (cnt_q == CNT_W'(LEN - 1))) begin
                        out_re_d    = sum_re_c;
                        out_im_d    = sum_im_c;
                        out_count_d = cnt_q + CNT_W'(1);
                        out_ovf_d   = ovf_q | sat_re_c | sat_im_c;
                        acc_re_d    = '0;
                        acc_im_d    = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = ST_HOLD;
                    end else begin
                        acc_re_d = sum_re_c;
                        acc_im_d = sum_im_c;
                        cnt_d    = cnt_q + CNT_W'(1);
                        ovf_d    = ovf_q | sat_re_c | sat_im_c;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: ;
        endcase
        // Handshake flags track the state being entered so they are registered.
        in_ready_d  = (state_d == ST_ACC);
        out_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_re_q    <= acc_re_d;
            acc_im_q    <= acc_im_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule
